// File: rtl/scope_key_debounce.sv
// Six-key front-panel debouncer with per-key auto-repeat; key_out is registered and changes on the
// debounce-acceptance edge. Latency is 2 synchronizer clk plus at most DEBOUNCE_TICKS ticks; there is no backpressure.
module scope_key_debounce #(
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] key_in,
    input  logic [5:0] repeat_en,
    output logic [5:0] key_out
);

    localparam int NKEYS = 6;
    localparam int PW    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW    = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int RMAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW    = $clog2(RMAX + 1);

    // A zero load would let the repeat counter sit below 1; clamp both loads to 1.
    localparam int DELAY_LD = (REPEAT_DELAY < 1) ? 1 : REPEAT_DELAY;
    localparam int RATE_LD  = (REPEAT_RATE < 1) ? 1 : REPEAT_RATE;

    localparam logic [1:0] ST_RELEASED = 2'd0;
    localparam logic [1:0] ST_PRESSED  = 2'd1;
    localparam logic [1:0] ST_GAP      = 2'd2;

    logic [NKEYS-1:0] sync_meta;
    logic [NKEYS-1:0] sync_key;
    logic [PW-1:0]    presc;
    logic             tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '1;
            sync_key  <= '1;
        end else begin
            sync_meta <= key_in;
            sync_key  <= sync_meta;
        end
    end

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    for (genvar k = 0; k < NKEYS; k++) begin : g_key
        logic          stable;
        logic [DW-1:0] db_cnt;
        logic [1:0]    state;
        logic [RW-1:0] rep_cnt;
        logic          key_q;
        logic          accept;
        logic          press;
        logic          release_evt;

        // Acceptance is decided combinationally so the FSM moves on the same edge that stable toggles.
        assign accept      = tick && (sync_key[k] != stable) && (db_cnt == DW'(DEBOUNCE_TICKS - 1));
        assign press       = accept && stable;
        assign release_evt = accept && !stable;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stable <= 1'b1;
                db_cnt <= '0;
            end else if (sync_key[k] == stable) begin
                db_cnt <= '0;
            end else if (tick) begin
                if (db_cnt == DW'(DEBOUNCE_TICKS - 1)) begin
                    stable <= ~stable;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state   <= ST_RELEASED;
                rep_cnt <= '0;
                key_q   <= 1'b1;
            end else begin
                case (state)
                    ST_RELEASED: begin
                        if (press) begin
                            state   <= ST_PRESSED;
                            rep_cnt <= RW'(DELAY_LD);
                            key_q   <= 1'b0;
                        end
                    end
                    ST_PRESSED: begin
                        if (release_evt) begin
                            state <= ST_RELEASED;
                            key_q <= 1'b1;
                        end else if (tick) begin
                            // With repeat disabled the counter parks at 1 until enabled or released.
                            if (rep_cnt == RW'(1)) begin
                                if (repeat_en[k]) begin
                                    state <= ST_GAP;
                                    key_q <= 1'b1;
                                end
                            end else begin
                                rep_cnt <= rep_cnt - RW'(1);
                            end
                        end
                    end
                    ST_GAP: begin
                        if (release_evt) begin
                            state <= ST_RELEASED;
                            key_q <= 1'b1;
                        end else if (tick) begin
                            state   <= ST_PRESSED;
                            rep_cnt <= RW'(RATE_LD);
                            key_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_RELEASED;
                        key_q <= 1'b1;
                    end
                endcase
            end
        end

        assign key_out[k] = key_q;
    end

endmodule

// File: tb/tb_scope_key_debounce.sv
// Bench for scope_key_debounce: directed vector table, reset corners and random keys against an arithmetic model.
module tb_scope_key_debounce;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] key_in = 6'h3F;
    logic [5:0] repeat_en = 6'h00;
    logic [5:0] key_out;

    always #5 clk = ~clk;

    scope_key_debounce #(
        .TICK_DIV(TD), .DEBOUNCE_TICKS(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .reset_n(reset_n), .key_in(key_in), .repeat_en(repeat_en), .key_out(key_out)
    );

    int total = 0;
    int bad = 0;

    // Reference model: edges counted from reset release; ticks land on every TD-th edge.
    int         n_edge;
    logic [5:0] hist[$];
    logic       m_stable[6];
    int         mis_start[6];
    int         press_edge[6];
    logic [5:0] m_out;

    function automatic void model_reset();
        n_edge = 0;
        hist = {};
        hist.push_back(6'h3F);
        hist.push_back(6'h3F);
        for (int k = 0; k < 6; k++) begin
            m_stable[k] = 1'b1;
            mis_start[k] = 0;
            press_edge[k] = 0;
        end
        m_out = 6'h3F;
    endfunction

    function automatic void model_edge();
        logic [5:0] seen;
        int kk;
        n_edge++;
        seen = hist.pop_front();
        hist.push_back(key_in);
        for (int k = 0; k < 6; k++) begin
            if (seen[k] == m_stable[k]) begin
                mis_start[k] = 0;
            end else begin
                if (mis_start[k] == 0) mis_start[k] = n_edge;
                // Accept once DB ticks have fallen inside an unbroken mismatch run.
                if ((n_edge % TD == 0) && ((n_edge / TD - (mis_start[k] - 1) / TD) == DB)) begin
                    m_stable[k] = ~m_stable[k];
                    mis_start[k] = 0;
                    if (!m_stable[k]) press_edge[k] = n_edge;
                end
            end
            if (m_stable[k]) begin
                m_out[k] = 1'b1;
            end else begin
                kk = n_edge / TD - press_edge[k] / TD;
                if (!repeat_en[k] || kk < RD) m_out[k] = 1'b0;
                else m_out[k] = (((kk - RD) % (RR + 1)) == 0);
            end
        end
    endfunction

    function automatic void check(input string name, input logic [5:0] act, input logic [5:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @edge %0d: key_out=%h required=%h", name, n_edge, act, exp);
        end
    endfunction

    task automatic step(input int ncyc, input string tag);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            model_edge();
            check(tag, key_out, m_out);
        end
    endtask

    typedef struct {
        logic [5:0] kin;
        logic [5:0] ren;
        int         ncyc;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Edge numbers in comments count from reset release.
        tbl.push_back('{6'h3E, 6'h00, 11, 6'h3F}); // 1..11 clean press, not yet accepted
        tbl.push_back('{6'h3E, 6'h00,  1, 6'h3E}); // 12 accepted
        tbl.push_back('{6'h3F, 6'h00, 11, 6'h3E}); // 13..23
        tbl.push_back('{6'h3F, 6'h00,  1, 6'h3F}); // 24 released
        tbl.push_back('{6'h3F, 6'h00,  8, 6'h3F});
        tbl.push_back('{6'h3D, 6'h00,  8, 6'h3F}); // bounce on key 1
        tbl.push_back('{6'h3F, 6'h00,  8, 6'h3F});
        tbl.push_back('{6'h3D, 6'h00,  8, 6'h3F});
        tbl.push_back('{6'h3F, 6'h00,  8, 6'h3F}); // 57..64
        tbl.push_back('{6'h3B, 6'h04, 11, 6'h3F}); // 65..75 auto-repeat hold
        tbl.push_back('{6'h3B, 6'h04,  1, 6'h3B}); // 76 press
        tbl.push_back('{6'h3B, 6'h04, 19, 6'h3B});
        tbl.push_back('{6'h3B, 6'h04,  1, 6'h3F}); // 96 first gap
        tbl.push_back('{6'h3B, 6'h04,  3, 6'h3F});
        tbl.push_back('{6'h3B, 6'h04,  1, 6'h3B}); // 100
        tbl.push_back('{6'h3B, 6'h04,  7, 6'h3B});
        tbl.push_back('{6'h3B, 6'h04,  1, 6'h3F}); // 108
        tbl.push_back('{6'h3B, 6'h04,  3, 6'h3F});
        tbl.push_back('{6'h3B, 6'h04,  1, 6'h3B}); // 112
        tbl.push_back('{6'h3B, 6'h04,  7, 6'h3B});
        tbl.push_back('{6'h3B, 6'h04,  1, 6'h3F}); // 120
        tbl.push_back('{6'h3B, 6'h04,  3, 6'h3F});
        tbl.push_back('{6'h3B, 6'h04,  1, 6'h3B}); // 124 end of 60-clk hold
        tbl.push_back('{6'h3F, 6'h04,  7, 6'h3B}); // 125..131
        tbl.push_back('{6'h3F, 6'h04,  1, 6'h3F}); // 132 gap
        tbl.push_back('{6'h3F, 6'h04,  3, 6'h3F});
        tbl.push_back('{6'h3F, 6'h04,  1, 6'h3F}); // 136 release beats gap exit
        tbl.push_back('{6'h3F, 6'h04,  4, 6'h3F});
        tbl.push_back('{6'h3B, 6'h00, 11, 6'h3F}); // 141..151 repeat disabled
        tbl.push_back('{6'h3B, 6'h00,  1, 6'h3B}); // 152
        tbl.push_back('{6'h3B, 6'h00, 48, 6'h3B}); // ..200
        tbl.push_back('{6'h3F, 6'h00, 11, 6'h3B});
        tbl.push_back('{6'h3F, 6'h00,  1, 6'h3F}); // 212
        tbl.push_back('{6'h2E, 6'h00, 11, 6'h3F}); // simultaneous keys 0 and 4
        tbl.push_back('{6'h2E, 6'h00,  1, 6'h2E}); // 224
        tbl.push_back('{6'h3F, 6'h00, 11, 6'h2E});
        tbl.push_back('{6'h3F, 6'h00,  1, 6'h3F}); // 236

        reset_n = 1'b0;
        key_in = 6'h3F;
        repeat_en = 6'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", key_out, 6'h3F);
        reset_n = 1'b1;
        model_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            key_in = tbl[i].kin;
            repeat_en = tbl[i].ren;
            step(tbl[i].ncyc, "model_directed");
            check($sformatf("table[%0d]", i), key_out, tbl[i].exp);
        end

        // Reset mid-press: output returns high without a clock, then needs a full debounce again.
        key_in = 6'h3E;
        repeat_en = 6'h00;
        step(12, "model_prereset");
        check("pressed_before_reset", key_out, 6'h3E);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_reset", key_out, 6'h3F);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("held_in_reset", key_out, 6'h3F);
        reset_n = 1'b1;
        model_reset();
        step(11, "model_postreset");
        check("no_early_press", key_out, 6'h3F);
        step(1, "model_postreset");
        check("repress_after_reset", key_out, 6'h3E);
        key_in = 6'h3F;
        step(20, "model_postreset");

        // Random segments: repeat_en fixed per segment, keys released at segment end.
        for (int seg = 0; seg < 10; seg++) begin
            int pmax[6];
            repeat_en = 6'($urandom);
            for (int k = 0; k < 6; k++) begin
                case ($urandom_range(0, 2))
                    0: pmax[k] = 2;
                    1: pmax[k] = 30;
                    default: pmax[k] = 120;
                endcase
            end
            for (int c = 0; c < 150; c++) begin
                for (int k = 0; k < 6; k++)
                    if ($urandom_range(0, pmax[k]) == 0) key_in[k] = ~key_in[k];
                step(1, "random");
            end
            key_in = 6'h3F;
            step(20, "random_release");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scope_key_debounce.md
SCOPE_KEY_DEBOUNCE -- requirements
Module: scope_key_debounce

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000: clk cycles per debounce tick (1 ms at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 20: consecutive ticks a changed input must hold before acceptance; legal range >= 1.
REQ-003 SHALL have parameter REPEAT_DELAY, default 500: ticks from accepted press to first auto-repeat.
REQ-004 SHALL have parameter REPEAT_RATE, default 100: ticks between subsequent auto-repeats.
REQ-005 SHALL have port clk, input, 1: system clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port key_in, input, 6: raw front-panel keys, active-low, asynchronous to clk, may bounce.
REQ-008 SHALL have port repeat_en, input, 6: per-key auto-repeat enable, sampled every clk.
REQ-009 SHALL have port key_out, output, 6: debounced keys, active-low, registered; drives the PIO in_port, whose falling-edge capture sees one event per press or repeat.

Function
REQ-010 SHALL pass each key_in bit through a 2-flop synchronizer; sync_key is the second flop.
REQ-011 SHALL count clk with a shared prescaler 0..TICK_DIV-1 and assert tick for exactly one clk when the count equals TICK_DIV-1, then wrap to 0.
REQ-012 SHALL keep a per-key stable bit and debounce counter; the counter SHALL clear on every clk where sync_key equals stable.
REQ-013 SHALL, on a tick with sync_key != stable, increment the counter; if the counter already equals DEBOUNCE_TICKS-1, stable SHALL toggle and the counter clear on the same edge.
REQ-014 SHALL run a per-key FSM with states RELEASED (key_out=1), PRESSED (key_out=0) and GAP (key_out=1).
REQ-015 SHALL move RELEASED->PRESSED on the clk where stable goes 0, and load the repeat counter with REPEAT_DELAY.
REQ-016 SHALL, in PRESSED, decrement the repeat counter on each tick; on a tick where it equals 1 and repeat_en is 1, go to GAP; with repeat_en 0 the counter SHALL hold at 1.
REQ-017 SHALL stay in GAP for exactly one tick interval, then on the next tick return to PRESSED and load REPEAT_RATE.
REQ-018 SHALL go to RELEASED from PRESSED or GAP on the clk where stable goes 1; release SHALL take priority over a simultaneous repeat or GAP exit.
REQ-019 SHALL drive key_out combinationally-free: each bit is a flop updated on the same edge as its FSM transition, so transitions are visible 1 clk after the deciding edge.
REQ-020 SHALL size every counter with $clog2 of its maximum value, with no overflow: the debounce counter never exceeds DEBOUNCE_TICKS-1 and the repeat counter never goes below 1.
REQ-021 SHALL process the six keys independently; a simultaneous press on several keys SHALL produce simultaneous falling edges.
REQ-022 SHALL bound worst-case press latency from key_in settling to 2 + TICK_DIV*DEBOUNCE_TICKS + 1 clk.

Reset
REQ-023 SHALL, while reset_n is 0, force the synchronizer flops and stable to 1, key_out to 6'h3F, all FSMs to RELEASED, and all counters and the prescaler to 0.
REQ-024 SHALL, after reset deassertion with key_in held low, produce no key_out falling edge until the full debounce period has elapsed.
REQ-025 SHALL, on reset asserted mid-press or mid-GAP, return key_out to 1 asynchronously.

Verification (TICK_DIV=4, DEBOUNCE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2)
REQ-026 SHALL cover a clean press: key_in[0] 1->0 held -> key_out[0] falls within 2+12+1 clk, other bits stay 1.
REQ-027 SHALL cover bounce rejection: key_in[1] low for 8 clk, then high, repeated -> key_out[1] stays 1 throughout.
REQ-028 SHALL cover auto-repeat: key[2] held 60 clk with repeat_en[2]=1 -> key_out[2] is low, then 4-clk high pulses at 20 clk after press, then every 12 clk.
REQ-029 SHALL cover repeat disabled: the same stimulus with repeat_en[2]=0 -> key_out[2] stays low, with no pulses.
REQ-030 SHALL cover release during GAP: release timed to accept inside GAP -> key_out[2] stays 1 and the FSM is RELEASED.
REQ-031 SHALL cover reset mid-press: reset_n pulsed low while key_out=6'h3E -> key_out=6'h3F immediately, then re-falls only after the full debounce period.
